floor_request_scheduler: RTL and testbench

Front end of the elevator. It debounces the active-low call buttons and latches each press as a pending request. A SCAN (elevator-algorithm) scheduler picks one target floor and drives it into the elevator state machine's requested_floor input. It watches the car's current_floor and idle status to retire requests once the car has arrived.

---
 rtl/floor_request_scheduler_pkg.sv | 12 +
 rtl/floor_request_scheduler_if.sv | 19 +
 rtl/floor_request_scheduler_button_debouncer.sv | 25 ++
 rtl/floor_request_scheduler.sv | 82 ++++++++
 tb/tb_floor_request_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/floor_request_scheduler_pkg.sv
// floor_request_scheduler_pkg: shared floor count, widths and scheduler state encodings.
package floor_request_scheduler_pkg;
    localparam int NUM_FLOORS = 9;
    localparam int FLOOR_W = 4;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_UP = 2'b10;
    localparam logic [1:0] S_DOWN = 2'b11;
    // Positions past the top floor are treated as the top floor.
    function automatic logic [FLOOR_W-1:0] clamp_floor(input logic [FLOOR_W-1:0] f);
        return (f > FLOOR_W'(NUM_FLOORS - 1)) ? FLOOR_W'(NUM_FLOORS - 1) : f;
    endfunction
endpackage

// File: rtl/floor_request_scheduler_if.sv
// floor_request_scheduler_if: call buttons and car status in, target floor and request state out.
interface floor_request_scheduler_if;
    import floor_request_scheduler_pkg::*;
    logic [NUM_FLOORS-2:0] btn_n;
    logic home_btn_n;
    logic [FLOOR_W-1:0] current_floor;
    logic car_idle;
    logic [FLOOR_W-1:0] requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic req_valid;
    modport master (
        output btn_n, home_btn_n, current_floor, car_idle,
        input requested_floor, pending, req_valid
    );
    modport slave (
        input btn_n, home_btn_n, current_floor, car_idle,
        output requested_floor, pending, req_valid
    );
endinterface

// File: rtl/floor_request_scheduler_button_debouncer.sv
// button_debouncer: 2-flop synchroniser plus stable-low counter; one accept pulse per press.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    input logic btn_n,
    output logic accept
);
    logic [1:0] sync;
    logic [CNT_W-1:0] cnt;
    // Counter saturates at the threshold so a held button never fires again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
            cnt <= '0;
            accept <= 1'b0;
        end else begin
            sync <= {sync[0], btn_n};
            cnt <= sync[1] ? '0 : (cnt == CNT_W'(DEBOUNCE_CYCLES)) ? cnt : cnt + 1'b1;
            accept <= !sync[1] && cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
        end
    end
endmodule

// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: latches debounced floor calls and picks a SCAN target for the car.
module floor_request_scheduler
    import floor_request_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    floor_request_scheduler_if.slave bus
);
    logic [NUM_FLOORS-1:0] buttons, accept, occupied, pending_n, pending_q, only_cf;
    logic [FLOOR_W-1:0] cf, above, below, nearest, idle_tgt, req_q, req_n;
    logic [1:0] state_q, state_n;
    logic has_above, has_below, hold, valid_q;

    assign buttons = {bus.btn_n, bus.home_btn_n};
    assign cf = clamp_floor(bus.current_floor);

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
            .clk(clk),
            .rst_n(rst_n),
            .btn_n(buttons[i]),
            .accept(accept[i])
        );
        assign occupied[i] = bus.car_idle && cf == FLOOR_W'(i);
    end

    // Arrival clear beats a same-cycle press only at the occupied floor.
    assign pending_n = (pending_q | accept) & ~occupied;

    always_comb begin
        above = '0;
        below = '0;
        has_above = 1'b0;
        has_below = 1'b0;
        for (int f = NUM_FLOORS - 1; f >= 0; f--)
            if (pending_q[f] && FLOOR_W'(f) > cf) begin
                has_above = 1'b1;
                above = FLOOR_W'(f);
            end
        for (int f = 0; f < NUM_FLOORS; f++)
            if (pending_q[f] && FLOOR_W'(f) < cf) begin
                has_below = 1'b1;
                below = FLOOR_W'(f);
            end
    end

    assign nearest = (has_above && (!has_below || (above - cf) <= (cf - below))) ? above : below;
    assign idle_tgt = pending_q[cf] ? cf : nearest;
    assign only_cf = NUM_FLOORS'(1) << cf;
    // Freeze the target while the car sits at it so the clear lands first.
    assign hold = bus.car_idle && cf == req_q && pending_q[req_q];

    always_comb begin
        {state_n, req_n} = hold ? {state_q, req_q}
            : pending_q == '0 ? {S_IDLE, cf}
            : state_q == S_IDLE ? (idle_tgt > cf ? {S_UP, idle_tgt}
                : pending_q == only_cf ? {S_IDLE, cf} : {S_DOWN, idle_tgt})
            : state_q == S_UP ? (has_above ? {S_UP, above} : has_below ? {S_DOWN, below} : {S_IDLE, cf})
            : (has_below ? {S_DOWN, below} : has_above ? {S_UP, above} : {S_IDLE, cf});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            valid_q <= 1'b0;
            state_q <= S_IDLE;
            req_q <= '0;
        end else begin
            pending_q <= pending_n;
            valid_q <= |pending_n;
            state_q <= state_n;
            req_q <= req_n;
        end
    end

    assign bus.pending = pending_q;
    assign bus.req_valid = valid_q;
    assign bus.requested_floor = req_q;
endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: table vectors, directed corner sequences and a random run vs a reference model.
module tb_floor_request_scheduler;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int nerr = 0;
    int nchk = 0;

    floor_request_scheduler_if bus();

    floor_request_scheduler #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: run length of raw low samples, fixed 3-edge pipeline to the pending set.
    int m_run [9];
    logic [2:0] m_dly [9];
    logic [8:0] m_pend;
    int m_req;
    int m_st;

    function automatic void model_reset();
        for (int f = 0; f < 9; f++) begin
            m_run[f] = 0;
            m_dly[f] = 3'b000;
        end
        m_pend = '0;
        m_req = 0;
        m_st = 0;
    endfunction

    function automatic void model_edge();
        logic [8:0] btns;
        logic [8:0] set;
        logic [8:0] newp;
        logic ev;
        int cf, nst, nreq, up, dn, best, bestd, d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        btns = {bus.btn_n, bus.home_btn_n};
        cf = (int'(bus.current_floor) > 8) ? 8 : int'(bus.current_floor);
        for (int f = 0; f < 9; f++) begin
            set[f] = m_dly[f][2];
            ev = 1'b0;
            if (!btns[f]) begin
                if (m_run[f] == D - 1) ev = 1'b1;
                if (m_run[f] < D) m_run[f]++;
            end else m_run[f] = 0;
            m_dly[f] = {m_dly[f][1:0], ev};
        end
        nst = m_st;
        nreq = m_req;
        if (bus.car_idle && cf == m_req && m_pend[m_req]) begin
            nst = m_st;
        end else if (m_pend == 0) begin
            nst = 0;
            nreq = cf;
        end else begin
            up = -1; dn = -1; best = -1; bestd = 99;
            for (int f = 8; f >= 0; f--) begin
                if (m_pend[f] && f > cf) up = f;
                if (m_pend[f] && f < cf && dn < 0) dn = f;
                d = (f > cf) ? f - cf : cf - f;
                if (m_pend[f] && d < bestd) begin
                    best = f;
                    bestd = d;
                end
            end
            if (m_st == 0) begin
                if (best > cf) begin nst = 1; nreq = best; end
                else if (m_pend == (9'd1 << cf)) begin nst = 0; nreq = cf; end
                else begin nst = 2; nreq = best; end
            end else if (m_st == 1) begin
                if (up >= 0) begin nst = 1; nreq = up; end
                else if (dn >= 0) begin nst = 2; nreq = dn; end
                else begin nst = 0; nreq = cf; end
            end else begin
                if (dn >= 0) begin nst = 2; nreq = dn; end
                else if (up >= 0) begin nst = 1; nreq = up; end
                else begin nst = 0; nreq = cf; end
            end
        end
        for (int f = 0; f < 9; f++)
            newp[f] = (bus.car_idle && cf == f) ? 1'b0 : (m_pend[f] | set[f]);
        m_pend = newp;
        m_st = nst;
        m_req = nreq;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [8:0] mask);
        bus.home_btn_n = ~mask[0];
        bus.btn_n = ~mask[8:1];
    endtask

    task automatic do_reset();
        set_btns(9'h000);
        rst_n = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [8:0] mask, input int n);
        set_btns(mask);
        repeat (n) tick();
        set_btns(9'h000);
    endtask

    typedef struct {
        int cf;
        logic idle;
        logic [8:0] mask;
        int exp_req;
        logic [8:0] exp_pend;
    } vec_t;

    vec_t vecs [8];
    logic [8:0] lv;
    int car;
    int mv;

    initial begin
        bus.current_floor = 4'd0;
        bus.car_idle = 1'b1;
        set_btns(9'h000);
        vecs[0] = '{cf: 0, idle: 1'b0, mask: 9'h040, exp_req: 6, exp_pend: 9'h040};
        vecs[1] = '{cf: 4, idle: 1'b1, mask: 9'h044, exp_req: 6, exp_pend: 9'h044};
        vecs[2] = '{cf: 4, idle: 1'b1, mask: 9'h010, exp_req: 4, exp_pend: 9'h000};
        vecs[3] = '{cf: 5, idle: 1'b0, mask: 9'h102, exp_req: 8, exp_pend: 9'h102};
        vecs[4] = '{cf: 5, idle: 1'b0, mask: 9'h108, exp_req: 3, exp_pend: 9'h108};
        vecs[5] = '{cf: 12, idle: 1'b0, mask: 9'h081, exp_req: 7, exp_pend: 9'h081};
        vecs[6] = '{cf: 12, idle: 1'b1, mask: 9'h100, exp_req: 8, exp_pend: 9'h000};
        vecs[7] = '{cf: 3, idle: 1'b0, mask: 9'h008, exp_req: 3, exp_pend: 9'h008};

        do_reset();
        chk("reset_pending", int'(bus.pending), 0);
        chk("reset_req", int'(bus.requested_floor), 0);
        chk("reset_valid", int'(bus.req_valid), 0);

        for (int v = 0; v < 8; v++) begin
            do_reset();
            bus.current_floor = 4'(vecs[v].cf);
            bus.car_idle = vecs[v].idle;
            tick();
            press(vecs[v].mask, D + 4);
            tick();
            tick();
            chk($sformatf("vec%0d_req", v), int'(bus.requested_floor), vecs[v].exp_req);
            chk($sformatf("vec%0d_pending", v), int'(bus.pending), int'(vecs[v].exp_pend));
            chk($sformatf("vec%0d_valid", v), int'(bus.req_valid), int'(vecs[v].exp_pend != 0));
        end

        // Short glitch is rejected; a held press lands exactly at edge 3+D.
        do_reset();
        bus.current_floor = 4'd0;
        bus.car_idle = 1'b0;
        press(9'h008, 3);
        repeat (6) tick();
        chk("glitch_pending", int'(bus.pending), 0);
        set_btns(9'h008);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == D + 2) chk("press_early", int'(bus.pending), 0);
            if (k == D + 3) chk("press_latch", int'(bus.pending), 9'h008);
        end
        chk("press_held", int'(bus.pending), 9'h008);
        chk("press_valid", int'(bus.req_valid), 1);
        set_btns(9'h000);

        // SCAN up with an en-route pickup.
        do_reset();
        bus.current_floor = 4'd0;
        bus.car_idle = 1'b1;
        press(9'h040, D + 4);
        chk("up_target", int'(bus.requested_floor), 6);
        bus.current_floor = 4'd2;
        bus.car_idle = 1'b0;
        set_btns(9'h010);
        repeat (D + 3) tick();
        chk("pickup_pend", int'(bus.pending), 9'h050);
        chk("pickup_before", int'(bus.requested_floor), 6);
        tick();
        chk("pickup_retarget", int'(bus.requested_floor), 4);
        set_btns(9'h000);
        bus.current_floor = 4'd4;
        bus.car_idle = 1'b1;
        tick();
        chk("arrive_clear", int'(bus.pending), 9'h040);
        chk("arrive_hold", int'(bus.requested_floor), 4);
        tick();
        chk("arrive_next", int'(bus.requested_floor), 6);

        // Reversal after the top-most request is served.
        do_reset();
        bus.current_floor = 4'd5;
        bus.car_idle = 1'b0;
        press(9'h084, D + 4);
        tick();
        chk("rev_target", int'(bus.requested_floor), 7);
        bus.current_floor = 4'd7;
        bus.car_idle = 1'b1;
        tick();
        chk("rev_clear", int'(bus.pending), 9'h004);
        chk("rev_hold", int'(bus.requested_floor), 7);
        tick();
        chk("rev_down", int'(bus.requested_floor), 2);

        // Asynchronous reset mid-travel, then a fresh press.
        do_reset();
        bus.current_floor = 4'd3;
        bus.car_idle = 1'b0;
        press(9'h120, D + 4);
        chk("mid_target", int'(bus.requested_floor), 5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_pending", int'(bus.pending), 0);
        chk("async_req", int'(bus.requested_floor), 0);
        chk("async_valid", int'(bus.req_valid), 0);
        tick();
        tick();
        chk("held_rst_pending", int'(bus.pending), 0);
        chk("held_rst_req", int'(bus.requested_floor), 0);
        rst_n = 1'b1;
        press(9'h002, D + 4);
        chk("after_rst_pend", int'(bus.pending), 9'h002);
        chk("after_rst_req", int'(bus.requested_floor), 1);

        // Random run: car follows the model's target; buttons toggle randomly.
        do_reset();
        lv = 9'h1ff;
        car = 0;
        mv = 0;
        for (int c = 0; c < 800; c++) begin
            for (int f = 0; f < 9; f++)
                if ($urandom_range(0, 5) == 0) lv[f] = ~lv[f];
            bus.home_btn_n = lv[0];
            bus.btn_n = lv[8:1];
            if (car > 8) car = 8;
            mv++;
            if ($urandom_range(0, 49) == 0) car = int'($urandom_range(9, 15));
            else if (mv % 3 == 0 && car != m_req) car += (m_req > car) ? 1 : -1;
            bus.current_floor = 4'(car);
            bus.car_idle = (car == m_req) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            tick();
            chk("rand_req", int'(bus.requested_floor), m_req);
            chk("rand_pending", int'(bus.pending), int'(m_pend));
            chk("rand_valid", int'(bus.req_valid), int'(m_pend != 0));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
